// File: rtl/psum_accum.sv
// Purpose: accumulate nkij partial-sum words per output pixel for an npix tile, then drain ReLU'd pixels.
// Latency: each pop updates acc[pix] at the next edge; a tile takes at least npix*nkij + npix + 1 cycles.
// Backpressure: ACCUM stalls while ofifo_valid=0; DRAIN holds out_data stable while out_ready=0.
module psum_accum #(
    parameter int psum_bw = 16,
    parameter int col     = 8,
    parameter int npix    = 16,
    parameter int nkij    = 9
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic                   ofifo_valid,
    input  logic [psum_bw*col-1:0] ofifo_data,
    output logic                   ofifo_rd,
    input  logic                   out_ready,
    output logic                   out_valid,
    output logic [psum_bw*col-1:0] out_data,
    output logic                   busy,
    output logic                   done
);

    localparam int DW = psum_bw * col;
    localparam int PW = (npix > 1) ? $clog2(npix) : 1;
    localparam int KW = (nkij > 1) ? $clog2(nkij) : 1;
    localparam logic [PW-1:0] PIX_LAST = PW'(npix - 1);
    localparam logic [KW-1:0] KIJ_LAST = KW'(nkij - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [DW-1:0]   r_acc [npix];
    logic [PW-1:0]   r_pix;
    logic [KW-1:0]   r_kij;

    logic [DW-1:0]   w_acc_cur;
    logic [DW-1:0]   w_acc_sum;
    logic [DW-1:0]   w_relu;
    logic            w_pix_last;
    logic            w_kij_last;
    logic            w_pop;
    logic            w_out_fire;

    assign w_acc_cur  = r_acc[r_pix];
    assign w_pix_last = (r_pix == PIX_LAST);
    assign w_kij_last = (r_kij == KIJ_LAST);
    assign w_pop      = ofifo_rd;
    assign w_out_fire = out_valid && out_ready;

    // Per-lane wrapping add of the FIFO head into the current pixel, and per-lane ReLU for drain.
    always_comb begin
        w_acc_sum = '0;
        w_relu    = '0;
        for (int i = 0; i < col; i++) begin
            w_acc_sum[i*psum_bw +: psum_bw] = w_acc_cur[i*psum_bw +: psum_bw]
                                            + ofifo_data[i*psum_bw +: psum_bw];
            w_relu[i*psum_bw +: psum_bw]    = w_acc_cur[i*psum_bw + psum_bw - 1]
                                            ? '0 : w_acc_cur[i*psum_bw +: psum_bw];
        end
    end

    // Next-state and output decode; start only matters in IDLE.
    always_comb begin
        w_state_nxt = r_state;
        ofifo_rd    = 1'b0;
        out_valid   = 1'b0;
        out_data    = '0;
        busy        = 1'b1;
        done        = 1'b0;
        case (r_state)
            S_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    w_state_nxt = S_ACCUM;
                end
            end
            S_ACCUM: begin
                ofifo_rd = ofifo_valid;
                if (ofifo_valid && w_pix_last && w_kij_last) begin
                    w_state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                out_valid = 1'b1;
                out_data  = w_relu;
                if (out_ready && w_pix_last) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                done        = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: begin
                busy        = 1'b0;
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Pixel/kernel-position counters: pix steps on every pop or drain handshake, kij on each pix wrap.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_pix <= '0;
            r_kij <= '0;
        end else if (w_pop) begin
            if (w_pix_last) begin
                r_pix <= '0;
                r_kij <= w_kij_last ? '0 : r_kij + 1'b1;
            end else begin
                r_pix <= r_pix + 1'b1;
            end
        end else if (w_out_fire) begin
            r_pix <= w_pix_last ? '0 : r_pix + 1'b1;
        end
    end

    // Accumulator: first kernel position overwrites, so no clear pass is needed between tiles.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int p = 0; p < npix; p++) begin
                r_acc[p] <= '0;
            end
        end else if (w_pop) begin
            r_acc[r_pix] <= (r_kij == '0) ? ofifo_data : w_acc_sum;
        end
    end

endmodule

// File: tb/tb_psum_accum.sv
// Purpose: scoreboard bench for psum_accum with a FIFO model on the input side and a monitor on the output side.
// Latency: expects npix*nkij + npix + 1 cycles from start to done when nothing stalls.
// Backpressure: optional random ofifo_valid gaps and a 5-cycle out_ready hold mid-drain.
module tb_psum_accum;

    localparam int PB       = 16;
    localparam int COL      = 8;
    localparam int NPIX     = 16;
    localparam int NKIJ     = 9;
    localparam int DW       = PB * COL;
    localparam int TILE_CYC = NPIX * NKIJ + NPIX + 1;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic          ofifo_valid = 1'b0;
    logic [DW-1:0] ofifo_data = '0;
    logic          out_ready = 1'b1;
    logic          ofifo_rd;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic          busy;
    logic          done;

    psum_accum #(.psum_bw(PB), .col(COL), .npix(NPIX), .nkij(NKIJ)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .ofifo_valid (ofifo_valid),
        .ofifo_data  (ofifo_data),
        .ofifo_rd    (ofifo_rd),
        .out_ready   (out_ready),
        .out_valid   (out_valid),
        .out_data    (out_data),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;

    int            n_checks = 0;
    int            n_errors = 0;
    logic [DW-1:0] fifo_q [$];
    logic [DW-1:0] exp_q [$];
    int            pop_cnt = 0;
    int            out_cnt = 0;
    int            done_cnt = 0;
    bit            stall_mode = 1'b0;

    task automatic checkw(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic checki(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Stimulus lane values per test id t, pixel p, kernel position k, lane l.
    function automatic int lane_val(input int t, input int p, input int k, input int l);
        if (t == 1) begin
            if (p == 3 && l == 0) return (k == 0) ? -5 : 2;
            if (p == 3 && l == 1) return 100;
            return 1;
        end
        if (t == 2) return (l == 0) ? -10 : 1;
        if (t == 3) begin
            if (l == 0) return (k == 0) ? 32767 : ((k == 1) ? 1 : 0);
            if (l == 1) return (k == 0) ? 32767 : 0;
            if (l == 2) return (k == 0) ? -32768 : 0;
            return 1;
        end
        if (t == 5) return 2;
        if (t == 6) return p + l;
        return 1;
    endfunction

    // Hand-derived post-ReLU results for the same tests.
    function automatic int exp_lane(input int t, input int p, input int l);
        if (t == 1) begin
            if (p == 3 && l == 0) return 11;
            if (p == 3 && l == 1) return 900;
            return 9;
        end
        if (t == 2) return (l == 0) ? 0 : 9;
        if (t == 3) begin
            if (l == 0) return 0;
            if (l == 1) return 32767;
            if (l == 2) return 0;
            return 9;
        end
        if (t == 5) return 18;
        if (t == 6) return 9 * (p + l);
        return 9;
    endfunction

    function automatic logic [DW-1:0] gen_word(input int t, input int p, input int k);
        logic [DW-1:0] w;
        w = '0;
        for (int l = 0; l < COL; l++) w[l*PB +: PB] = PB'(lane_val(t, p, k, l));
        return w;
    endfunction

    function automatic logic [DW-1:0] exp_word(input int t, input int p);
        logic [DW-1:0] w;
        w = '0;
        for (int l = 0; l < COL; l++) w[l*PB +: PB] = PB'(exp_lane(t, p, l));
        return w;
    endfunction

    task automatic load_tile(input int t);
        for (int k = 0; k < NKIJ; k++)
            for (int p = 0; p < NPIX; p++)
                fifo_q.push_back(gen_word(t, p, k));
        for (int p = 0; p < NPIX; p++) exp_q.push_back(exp_word(t, p));
    endtask

    // Upstream FIFO model: present head at negedge, retire it when the DUT pops.
    initial begin
        forever begin
            @(negedge clk);
            ofifo_valid = (fifo_q.size() > 0) && (!stall_mode || ($urandom_range(0, 1) == 1));
            ofifo_data  = (fifo_q.size() > 0) ? fifo_q[0] : '0;
            #1;
            if (!ofifo_valid || !busy) check1("rd_gated", ofifo_rd, 1'b0);
            if (ofifo_rd && ofifo_valid) begin
                void'(fifo_q.pop_front());
                pop_cnt++;
            end
        end
    end

    // Output monitor: compare each accepted pixel against the scoreboard, watch idle zeros and done width.
    initial begin
        logic [DW-1:0] exp_w;
        bit            prev_done;
        prev_done = 1'b0;
        forever begin
            @(negedge clk);
            #2;
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL out_unexpected: got %h expected no output", out_data);
                end else begin
                    exp_w = exp_q.pop_front();
                    checkw($sformatf("out_data[%0d]", out_cnt), out_data, exp_w);
                end
                out_cnt++;
            end
            if (!out_valid) checkw("out_idle_zero", out_data, '0);
            if (done) begin
                check1("done_one_cycle", prev_done, 1'b0);
                done_cnt++;
            end
            prev_done = done;
        end
    end

    task automatic wait_done(input bit inject, input bit stall_out, output int cyc);
        int            hold;
        bit            stalled;
        int            out0;
        logic [DW-1:0] held;
        hold    = 0;
        stalled = 1'b0;
        held    = '0;
        out0    = out_cnt;
        cyc     = -1;
        for (int i = 1; i <= 3000; i++) begin
            @(negedge clk);
            start = inject && (i == 10 || i == 150 || i == TILE_CYC);
            if (stall_out) begin
                if (hold > 0) begin
                    hold--;
                    check1("stall_valid", out_valid, 1'b1);
                    checkw("stall_data_held", out_data, held);
                    if (hold == 0) out_ready = 1'b1;
                end else if (!stalled && (out_cnt - out0) >= 8) begin
                    stalled   = 1'b1;
                    out_ready = 1'b0;
                    hold      = 5;
                    held      = out_data;
                end
            end
            #3;
            if (done) begin
                cyc = i;
                break;
            end
        end
        out_ready = 1'b1;
        if (cyc < 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL done_timeout: got no done expected done within 3000 cycles");
        end
    endtask

    task automatic run_tile(input int t, input bit do_load, input bit inject, input bit stall_out,
                            input int exp_cyc);
        int pops0;
        int done0;
        int cyc;
        if (do_load) load_tile(t);
        pops0 = pop_cnt;
        done0 = done_cnt;
        @(negedge clk);
        start = 1'b1;
        wait_done(inject, stall_out, cyc);
        if (exp_cyc > 0) checki("tile_latency", cyc, exp_cyc);
        checki("pop_count", pop_cnt - pops0, NPIX * NKIJ);
        @(negedge clk);
        start = 1'b0;
        #3;
        check1("busy_after_done", busy, 1'b0);
        check1("done_low_after", done, 1'b0);
        checki("done_count", done_cnt - done0, 1);
        checki("outputs_drained", exp_q.size(), 0);
        repeat (5) @(negedge clk);
        #3;
        check1("stays_idle", busy, 1'b0);
        checki("no_idle_pops", pop_cnt - pops0, NPIX * NKIJ);
    endtask

    initial begin
        int pops0;
        int done0;
        bit hit;

        // Reset with words waiting in the FIFO: nothing may be read or presented.
        for (int k = 0; k < 4; k++) fifo_q.push_back(gen_word(0, k, 0));
        repeat (3) @(negedge clk);
        #3;
        check1("reset_rd", ofifo_rd, 1'b0);
        check1("reset_out_valid", out_valid, 1'b0);
        checkw("reset_out_data", out_data, '0);
        check1("reset_busy", busy, 1'b0);
        check1("reset_done", done, 1'b0);
        fifo_q.delete();
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);

        run_tile(0, 1'b1, 1'b0, 1'b0, TILE_CYC);   // all ones -> all nines
        run_tile(1, 1'b1, 1'b0, 1'b0, TILE_CYC);   // sign handling on pixel 3
        run_tile(2, 1'b1, 1'b0, 1'b0, TILE_CYC);   // negative lane clipped by ReLU
        run_tile(3, 1'b1, 1'b0, 1'b0, TILE_CYC);   // wrap to 0x8000 clips, 0x7FFF passes
        stall_mode = 1'b1;
        run_tile(1, 1'b1, 1'b0, 1'b1, -1);          // same vectors with both-side stalls
        stall_mode = 1'b0;
        run_tile(6, 1'b1, 1'b1, 1'b0, TILE_CYC);   // distinct pixels, start pulses mid-tile

        // Abort a tile after 50 pops, then require a fresh start.
        load_tile(0);
        pops0 = pop_cnt;
        done0 = done_cnt;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        hit = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            #3;
            if (pop_cnt - pops0 >= 50) begin
                hit = 1'b1;
                break;
            end
        end
        check1("reach_50_pops", hit, 1'b1);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        #3;
        check1("midreset_busy", busy, 1'b0);
        check1("midreset_rd", ofifo_rd, 1'b0);
        check1("midreset_out_valid", out_valid, 1'b0);
        check1("midreset_done", done, 1'b0);
        fifo_q.delete();
        exp_q.delete();
        @(negedge clk);
        reset = 1'b1;
        load_tile(5);
        pops0 = pop_cnt;
        repeat (5) @(negedge clk);
        #3;
        check1("no_autostart_busy", busy, 1'b0);
        checki("no_autostart_pops", pop_cnt - pops0, 0);
        checki("aborted_no_done", done_cnt - done0, 0);
        run_tile(5, 1'b0, 1'b0, 1'b0, TILE_CYC);   // all twos -> all eighteens

        checki("final_scoreboard_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
